// File: rtl/fib_bcd_display.sv
// fib_bcd_display
//   Captures one 8-bit binary value per valid/ready handshake, converts it to
//   three BCD digits with a sequential shift-add-3 (one bit per clock), holds
//   the result and drives a 3-digit multiplexed, active-low 7-segment display.
//
//   state | meaning
//   IDLE  | ready for a new value (din_ready=1)
//   SHIFT | eight shift-add-3 steps in progress
//   DONE  | result just loaded, bcd_valid pulse
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   din[7:0], din_valid          input value and its qualifier
//   din_ready                    high in IDLE only
//   bcd_hundreds/tens/ones[3:0]  last completed conversion
//   bcd_valid                    one-cycle pulse when a new result loads
//   seg[6:0]                     {g,f,e,d,c,b,a}, active-low
//   an[2:0]                      digit enables, active-low, an[0]=ones
module fib_bcd_display #(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       bcd_valid,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  shreg;
  logic [11:0] scratch;
  logic [2:0]  bit_cnt;
  logic [11:0] adj;
  logic [19:0] shifted;
  logic        unused_carry;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       scan_idx;
  logic [3:0]       digit;
  logic             blank;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  // One double-dabble step: correct digits, then shift {scratch,shreg} left.
  // The top bit of the corrected scratch can never be set for 8-bit inputs
  // (hundreds stays <= 2), so dropping it loses nothing.
  assign adj          = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
  assign shifted      = {adj[10:0], shreg, 1'b0};
  assign unused_carry = adj[11];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (din_valid) state_next = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    din_ready = 1'b0;
    bcd_valid = 1'b0;
    case (state)
      IDLE:    din_ready = 1'b1;
      DONE:    bcd_valid = 1'b1;
      default: ;
    endcase
  end

  // Conversion datapath; bcd_* only change on the final shift so partial
  // values are never visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg        <= '0;
      scratch      <= '0;
      bit_cnt      <= '0;
      bcd_hundreds <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            shreg   <= din;
            scratch <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          scratch <= shifted[19:8];
          shreg   <= shifted[7:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            bcd_hundreds <= shifted[19:16];
            bcd_tens     <= shifted[15:12];
            bcd_ones     <= shifted[11:8];
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running scan, independent of conversions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt  <= '0;
      scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    digit = bcd_ones;
    blank = 1'b0;
    an    = 3'b110;
    case (scan_idx)
      2'd1: begin
        digit = bcd_tens;
        blank = BLANK_LZ && (bcd_hundreds == 4'd0) && (bcd_tens == 4'd0);
        an    = 3'b101;
      end
      2'd2: begin
        digit = bcd_hundreds;
        blank = BLANK_LZ && (bcd_hundreds == 4'd0);
        an    = 3'b011;
      end
      default: ;
    endcase
    seg = blank ? 7'h7F : seg_code(digit);
  end

endmodule
